preg_free_list: RTL and testbench

- Owns the physical-register free pool for the out-of-order core.
- Rename pops a free physical register for each destination. Commit pushes back the stale physical register of each retiring instruction.
- This block is the release/reclaim end of the allocation interface used by rename. Storage is a circular FIFO of free pReg IDs plus an in-pool bitmap that guards against double release.
- Sits between the rename stage (allocate side) and the ROB commit logic (release side).

---
 rtl/preg_free_list.sv | 101 ++++++++++
 tb/tb_preg_free_list.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/preg_free_list.sv
// preg_free_list: physical-register free pool for the out-of-order core.
//
// Rename pops free pRegs from the head of a circular FIFO; commit pushes the
// stale pReg of each retiring instruction back at the tail. An in-pool bitmap
// rejects double releases, which also bounds the pool at NUM_PREG-1 entries
// because p0 can never enter it.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   alloc_req       rename wants one pReg this cycle
//   alloc_ready     pool non-empty, alloc_preg valid
//   alloc_preg      head of the free FIFO (granted in the same cycle)
//   rel_valid       commit releases one pReg this cycle
//   rel_preg        pReg being released
//   free_count      pRegs currently in the pool
//   err_double_free sticky flag: a release was dropped as already free
module preg_free_list #(
    parameter int unsigned PREG_W   = 6,
    parameter int unsigned NUM_PREG = 64,
    parameter int unsigned NUM_ARCH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_ready,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              rel_valid,
    input  logic [PREG_W-1:0] rel_preg,
    output logic [PREG_W:0]   free_count,
    output logic              err_double_free
);

    localparam int unsigned       InitFree = NUM_PREG - NUM_ARCH;
    localparam logic [PREG_W-1:0] PtrOne   = 1;
    localparam logic [PREG_W:0]   CntOne   = 1;

    logic [PREG_W-1:0]   fifo_q [NUM_PREG];
    logic [NUM_PREG-1:0] in_pool_q;
    logic [PREG_W-1:0]   head_q, head_d;
    logic [PREG_W-1:0]   tail_q, tail_d;
    logic [PREG_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                rel_nonzero;
    logic                pop;
    logic                push;

    assign alloc_ready     = (count_q != '0);
    assign alloc_preg      = fifo_q[head_q];
    assign free_count      = count_q;
    assign err_double_free = err_q;

    always_comb begin
        // p0 is hardwired zero and is silently ignored on release.
        rel_nonzero = rel_valid && (rel_preg != '0);
        // Pop only from registered state: a same-cycle release is never bypassed.
        pop         = alloc_req && alloc_ready;
        push        = rel_nonzero && !in_pool_q[rel_preg];

        head_d  = pop  ? head_q + PtrOne : head_q;
        tail_d  = push ? tail_q + PtrOne : tail_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        err_d = err_q | (rel_nonzero & in_pool_q[rel_preg]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= PREG_W'(InitFree);
            count_q <= (PREG_W + 1)'(InitFree);
            err_q   <= 1'b0;
            // Architectural registers start mapped; the rest queue up in order.
            for (int unsigned i = 0; i < NUM_PREG; i++) begin
                fifo_q[i]    <= (i < InitFree) ? PREG_W'(NUM_ARCH + i) : '0;
                in_pool_q[i] <= (i >= NUM_ARCH);
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
            // Popped and pushed pRegs are always distinct: the popped one is in
            // the pool, an accepted release is not.
            if (pop) begin
                in_pool_q[alloc_preg] <= 1'b0;
            end
            if (push) begin
                in_pool_q[rel_preg] <= 1'b1;
                fifo_q[tail_q]      <= rel_preg;
            end
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed and random stimulus for preg_free_list with a queue/bitmap model.
module tb_preg_free_list;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_req = 1'b0;
    logic       alloc_ready;
    logic [5:0] alloc_preg;
    logic       rel_valid = 1'b0;
    logic [5:0] rel_preg = '0;
    logic [6:0] free_count;
    logic       err_double_free;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model for the random stream.
    int mq[$];
    bit in_pool[64];
    bit held[64];
    bit merr;

    preg_free_list #(
        .PREG_W  (6),
        .NUM_PREG(64),
        .NUM_ARCH(32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_req      (alloc_req),
        .alloc_ready    (alloc_ready),
        .alloc_preg     (alloc_preg),
        .rel_valid      (rel_valid),
        .rel_preg       (rel_preg),
        .free_count     (free_count),
        .err_double_free(err_double_free)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (free_count !== 7'd32) begin
            n_fail++; $display("FAIL reset_count got %0d want 32", free_count);
        end
        n_checks++;
        if (alloc_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b want 1", alloc_ready);
        end
        n_checks++;
        if (alloc_preg !== 6'd32) begin
            n_fail++; $display("FAIL reset_preg got %0d want 32", alloc_preg);
        end
        n_checks++;
        if (err_double_free !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got %b want 0", err_double_free);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        alloc_req = 1'b1;
        repeat (3) cyc();
        alloc_req = 1'b0;
        n_checks++;
        if (free_count !== 7'd29 || alloc_preg !== 6'd35) begin
            n_fail++;
            $display("FAIL pre_reset_state got count=%0d preg=%0d want 29/35",
                     free_count, alloc_preg);
        end
        // Mid-cycle asynchronous reset, checked before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (free_count !== 7'd32 || alloc_ready !== 1'b1 || alloc_preg !== 6'd32 ||
            err_double_free !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got count=%0d ready=%b preg=%0d err=%b want 32/1/32/0",
                     free_count, alloc_ready, alloc_preg, err_double_free);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_back_to_back();
        alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            n_checks++;
            if (alloc_ready !== 1'b1 || alloc_preg !== 6'(32 + i)) begin
                n_fail++;
                $display("FAIL drain_grant[%0d] got ready=%b preg=%0d want 1/%0d",
                         i, alloc_ready, alloc_preg, 32 + i);
            end
            cyc();
        end
        @(negedge clk);
        n_checks++;
        if (alloc_ready !== 1'b0 || free_count !== 7'd0) begin
            n_fail++;
            $display("FAIL drain_empty got ready=%b count=%0d want 0/0", alloc_ready, free_count);
        end
        cyc();
        alloc_req = 1'b0;
        n_checks++;
        if (alloc_ready !== 1'b0 || free_count !== 7'd0 || err_double_free !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_when_empty got ready=%b count=%0d err=%b want 0/0/0",
                     alloc_ready, free_count, err_double_free);
        end
    endtask

    task automatic test_empty_release();
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_preg  = 6'd40;
        @(negedge clk);
        n_checks++;
        if (alloc_ready !== 1'b0) begin
            n_fail++; $display("FAIL no_bypass got ready=%b want 0", alloc_ready);
        end
        cyc();
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        n_checks++;
        if (alloc_ready !== 1'b1 || alloc_preg !== 6'd40 || free_count !== 7'd1) begin
            n_fail++;
            $display("FAIL release_visible got ready=%b preg=%0d count=%0d want 1/40/1",
                     alloc_ready, alloc_preg, free_count);
        end
    endtask

    task automatic test_simultaneous();
        for (int r = 41; r <= 49; r++) begin
            rel_valid = 1'b1;
            rel_preg  = 6'(r);
            cyc();
        end
        rel_valid = 1'b0;
        n_checks++;
        if (free_count !== 7'd10) begin
            n_fail++; $display("FAIL fill_to_10 got %0d want 10", free_count);
        end
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_preg  = 6'd50;
        @(negedge clk);
        n_checks++;
        if (alloc_preg !== 6'd40) begin
            n_fail++; $display("FAIL simul_grant got %0d want 40", alloc_preg);
        end
        cyc();
        rel_valid = 1'b0;
        n_checks++;
        if (free_count !== 7'd10) begin
            n_fail++; $display("FAIL simul_count got %0d want 10", free_count);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (alloc_preg !== ((i < 9) ? 6'(41 + i) : 6'd50)) begin
                n_fail++;
                $display("FAIL simul_drain[%0d] got %0d want %0d", i, alloc_preg,
                         (i < 9) ? 41 + i : 50);
            end
            cyc();
        end
        alloc_req = 1'b0;
        n_checks++;
        if (free_count !== 7'd0) begin
            n_fail++; $display("FAIL simul_drained got %0d want 0", free_count);
        end
        // Push/pop pairs carry both pointers past the wrap point.
        for (int k = 0; k < 60; k++) begin
            rel_valid = 1'b1;
            rel_preg  = 6'(1 + k);
            cyc();
            rel_valid = 1'b0;
            alloc_req = 1'b1;
            @(negedge clk);
            n_checks++;
            if (alloc_ready !== 1'b1 || alloc_preg !== 6'(1 + k)) begin
                n_fail++;
                $display("FAIL wrap_grant[%0d] got ready=%b preg=%0d want 1/%0d",
                         k, alloc_ready, alloc_preg, 1 + k);
            end
            cyc();
            alloc_req = 1'b0;
        end
        n_checks++;
        if (free_count !== 7'd0) begin
            n_fail++; $display("FAIL wrap_end_count got %0d want 0", free_count);
        end
    endtask

    task automatic test_double_free();
        rel_valid = 1'b1;
        rel_preg  = 6'd0;
        cyc();
        rel_valid = 1'b0;
        n_checks++;
        if (free_count !== 7'd0 || err_double_free !== 1'b0 || alloc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_p0 got count=%0d err=%b ready=%b want 0/0/0",
                     free_count, err_double_free, alloc_ready);
        end
        rel_valid = 1'b1;
        rel_preg  = 6'd35;
        cyc();
        n_checks++;
        if (free_count !== 7'd1 || err_double_free !== 1'b0) begin
            n_fail++;
            $display("FAIL release_35 got count=%0d err=%b want 1/0", free_count, err_double_free);
        end
        cyc();
        rel_valid = 1'b0;
        n_checks++;
        if (free_count !== 7'd1 || err_double_free !== 1'b1 || alloc_preg !== 6'd35) begin
            n_fail++;
            $display("FAIL double_free got count=%0d err=%b preg=%0d want 1/1/35",
                     free_count, err_double_free, alloc_preg);
        end
        repeat (100) cyc();
        n_checks++;
        if (err_double_free !== 1'b1 || free_count !== 7'd1) begin
            n_fail++;
            $display("FAIL err_sticky got err=%b count=%0d want 1/1", err_double_free, free_count);
        end
    endtask

    task automatic test_random();
        int  pc;
        int  g;
        bit  pop;
        bit  rel_acc;
        bit  rel_dbl;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mq.delete();
        for (int i = 0; i < 64; i++) begin
            in_pool[i] = (i >= 32);
            held[i]    = (i < 32);
            if (i >= 32) mq.push_back(i);
        end
        merr = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            alloc_req = ($urandom_range(0, 9) < 6);
            rel_valid = 1'($urandom_range(0, 1));
            rel_preg  = 6'($urandom_range(0, 63));
            @(negedge clk);
            pc = 0;
            for (int i = 0; i < 64; i++) pc += int'(in_pool[i]);
            n_checks++;
            if (free_count !== 7'(pc)) begin
                n_fail++; $display("FAIL rnd_popcount c=%0d got %0d want %0d", c, free_count, pc);
            end
            n_checks++;
            if (alloc_ready !== (mq.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_ready c=%0d got %b want %b", c, alloc_ready, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                n_checks++;
                if (alloc_preg !== 6'(mq[0])) begin
                    n_fail++;
                    $display("FAIL rnd_preg c=%0d got %0d want %0d", c, alloc_preg, mq[0]);
                end
            end
            n_checks++;
            if (err_double_free !== merr) begin
                n_fail++;
                $display("FAIL rnd_err c=%0d got %b want %b", c, err_double_free, merr);
            end
            rel_acc = rel_valid && (rel_preg != 0) && !in_pool[rel_preg];
            rel_dbl = rel_valid && (rel_preg != 0) && in_pool[rel_preg];
            pop     = alloc_req && (mq.size() != 0);
            if (pop) begin
                g = mq.pop_front();
                n_checks++;
                if (held[alloc_preg]) begin
                    n_fail++;
                    $display("FAIL rnd_double_grant c=%0d got %0d want a pReg not held",
                             c, alloc_preg);
                end
                in_pool[g] = 1'b0;
                held[g]    = 1'b1;
            end
            if (rel_acc) begin
                mq.push_back(int'(rel_preg));
                in_pool[rel_preg] = 1'b1;
                held[rel_preg]    = 1'b0;
            end
            if (rel_dbl) merr = 1'b1;
            cyc();
        end
        alloc_req = 1'b0;
        rel_valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_empty_release();
        test_simultaneous();
        test_double_free();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
